// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and the datapath
// blocks (ALU, EXT, NPC, DM) that consume its control outputs.
package mc_pkg;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_ITYPE_ALU, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
    } iclass_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_LUI   = 5'd1;
    localparam logic [4:0] ALU_AUIPC = 5'd2;
    localparam logic [4:0] ALU_ADD   = 5'd3;
    localparam logic [4:0] ALU_SUB   = 5'd4;
    localparam logic [4:0] ALU_BNE   = 5'd5;
    localparam logic [4:0] ALU_BLT   = 5'd6;
    localparam logic [4:0] ALU_BGE   = 5'd7;
    localparam logic [4:0] ALU_BLTU  = 5'd8;
    localparam logic [4:0] ALU_BGEU  = 5'd9;
    localparam logic [4:0] ALU_SLT   = 5'd10;
    localparam logic [4:0] ALU_SLTU  = 5'd11;
    localparam logic [4:0] ALU_XOR   = 5'd12;
    localparam logic [4:0] ALU_OR    = 5'd13;
    localparam logic [4:0] ALU_AND   = 5'd14;
    localparam logic [4:0] ALU_SLL   = 5'd15;
    localparam logic [4:0] ALU_SRL   = 5'd16;
    localparam logic [4:0] ALU_SRA   = 5'd17;
    localparam logic [4:0] ALU_BEQ   = 5'd18;

    localparam logic [5:0] EXT_NONE   = 6'b000000;
    localparam logic [5:0] EXT_ISHAMT = 6'b100000;
    localparam logic [5:0] EXT_I      = 6'b010000;
    localparam logic [5:0] EXT_S      = 6'b001000;
    localparam logic [5:0] EXT_B      = 6'b000100;
    localparam logic [5:0] EXT_U      = 6'b000010;
    localparam logic [5:0] EXT_J      = 6'b000001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct fields to class,
// ALU/EXT/DM encodings and a legality flag.
import mc_pkg::*;

module mc_decode (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output iclass_t    cls,
    output logic [4:0] alu_op,
    output logic [5:0] ext_op,
    output logic [2:0] dm_type,
    output logic       legal
);

    always_comb begin
        cls     = CL_RTYPE;
        alu_op  = ALU_NOP;
        ext_op  = EXT_NONE;
        dm_type = DM_W;
        legal   = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls = CL_RTYPE;
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  alu_op = ALU_ADD;
                        3'b001:  alu_op = ALU_SLL;
                        3'b010:  alu_op = ALU_SLT;
                        3'b011:  alu_op = ALU_SLTU;
                        3'b100:  alu_op = ALU_XOR;
                        3'b101:  alu_op = ALU_SRL;
                        3'b110:  alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    legal  = (funct3 == 3'b000) || (funct3 == 3'b101);
                    alu_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end
            end
            OP_ITYPE: begin
                cls    = CL_ITYPE_ALU;
                ext_op = EXT_I;
                legal  = 1'b1;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        alu_op = ALU_SLL;
                        ext_op = EXT_ISHAMT;
                        legal  = (funct7 == F7_BASE);
                    end
                    default: begin
                        alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        ext_op = EXT_ISHAMT;
                        legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OP_LOAD: begin
                cls    = CL_LOAD;
                alu_op = ALU_ADD;
                ext_op = EXT_I;
                legal  = 1'b1;
                case (funct3)
                    3'b000:  dm_type = DM_B;
                    3'b001:  dm_type = DM_H;
                    3'b010:  dm_type = DM_W;
                    3'b100:  dm_type = DM_BU;
                    3'b101:  dm_type = DM_HU;
                    default: legal   = 1'b0;
                endcase
            end
            OP_STORE: begin
                cls    = CL_STORE;
                alu_op = ALU_ADD;
                ext_op = EXT_S;
                legal  = 1'b1;
                case (funct3)
                    3'b000:  dm_type = DM_B;
                    3'b001:  dm_type = DM_H;
                    3'b010:  dm_type = DM_W;
                    default: legal   = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                cls    = CL_BRANCH;
                ext_op = EXT_B;
                legal  = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALU_BEQ;
                    3'b001:  alu_op = ALU_BNE;
                    3'b100:  alu_op = ALU_BLT;
                    3'b101:  alu_op = ALU_BGE;
                    3'b110:  alu_op = ALU_BLTU;
                    3'b111:  alu_op = ALU_BGEU;
                    default: legal  = 1'b0;
                endcase
            end
            OP_JAL: begin
                cls    = CL_JAL;
                ext_op = EXT_J;
                legal  = 1'b1;
            end
            OP_JALR: begin
                cls    = CL_JALR;
                alu_op = ALU_ADD;
                ext_op = EXT_I;
                legal  = (funct3 == 3'b000);
            end
            OP_LUI: begin
                cls    = CL_LUI;
                alu_op = ALU_LUI;
                ext_op = EXT_U;
                legal  = 1'b1;
            end
            OP_AUIPC: begin
                cls    = CL_AUIPC;
                alu_op = ALU_AUIPC;
                ext_op = EXT_U;
                legal  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller: steps each instruction through
// fetch/decode/execute/memory/write-back over one shared memory port.
//   state  | meaning
//   S_IF   | fetch request at PC; IR/PC update on mem_ready
//   S_ID   | classify IR, latch class and control encodings
//   S_EX   | ALU operation; branches/jumps update PC
//   S_MEM  | load/store request at ALUOut
//   S_WB   | register-file write, retire
//   S_HALT | unsupported encoding seen; only reset leaves
import mc_pkg::*;

module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       Op,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [4:0]       ALUOp,
    output logic [5:0]       EXTOp,
    output logic [2:0]       NPCOp,
    output logic [1:0]       WDSel,
    output logic [2:0]       DMType,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    state_t           state_q, state_d;
    iclass_t          cls_q, cls_d;
    logic [4:0]       alu_op_q, alu_op_d;
    logic [5:0]       ext_op_q, ext_op_d;
    logic [2:0]       dm_type_q, dm_type_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    iclass_t    dec_cls;
    logic [4:0] dec_alu_op;
    logic [5:0] dec_ext_op;
    logic [2:0] dec_dm_type;
    logic       dec_legal;

    mc_decode u_decode (
        .op      (Op),
        .funct3  (Funct3),
        .funct7  (Funct7),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op),
        .ext_op  (dec_ext_op),
        .dm_type (dec_dm_type),
        .legal   (dec_legal)
    );

    // Outputs are decoded from the current state and gated by rstn so a
    // reset mid-request drops every strobe without waiting for a clock.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_op_d  = alu_op_q;
        ext_op_d  = ext_op_q;
        dm_type_d = dm_type_q;
        illegal_d = illegal_q;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        ALUOp     = ALU_NOP;
        EXTOp     = EXT_NONE;
        NPCOp     = NPC_PLUS4;
        WDSel     = WD_ALU;
        DMType    = DM_W;
        retire    = 1'b0;
        if (rstn) begin
            case (state_q)
                S_IF: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        NPCOp   = NPC_PLUS4;
                        state_d = S_ID;
                    end
                end
                S_ID: begin
                    cls_d     = dec_cls;
                    alu_op_d  = dec_alu_op;
                    ext_op_d  = dec_ext_op;
                    dm_type_d = dec_dm_type;
                    if (dec_legal) begin
                        state_d = S_EX;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
                S_EX: begin
                    ALUOp  = alu_op_q;
                    EXTOp  = ext_op_q;
                    ALUSrc = !(cls_q inside {CL_RTYPE, CL_BRANCH, CL_JAL});
                    case (cls_q)
                        CL_BRANCH: begin
                            PCWrite = Zero;
                            NPCOp   = {2'b00, Zero};
                            retire  = 1'b1;
                            state_d = S_IF;
                        end
                        CL_JAL: begin
                            PCWrite = 1'b1;
                            NPCOp   = NPC_JUMP;
                            state_d = S_WB;
                        end
                        CL_JALR: begin
                            PCWrite = 1'b1;
                            NPCOp   = NPC_JALR;
                            state_d = S_WB;
                        end
                        CL_LOAD, CL_STORE: state_d = S_MEM;
                        default:           state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = (cls_q == CL_STORE);
                    DMType   = dm_type_q;
                    if (mem_ready) begin
                        if (cls_q == CL_STORE) begin
                            retire  = 1'b1;
                            state_d = S_IF;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_IF;
                    case (cls_q)
                        CL_LOAD:         WDSel = WD_MEM;
                        CL_JAL, CL_JALR: WDSel = WD_PC;
                        default:         WDSel = WD_ALU;
                    endcase
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IF;
            endcase
        end
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IF;
            cls_q     <= CL_RTYPE;
            alu_op_q  <= ALU_NOP;
            ext_op_q  <= EXT_NONE;
            dm_type_q <= DM_W;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_op_q  <= alu_op_d;
            ext_op_q  <= ext_op_d;
            dm_type_q <= dm_type_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle strobe vectors for each instruction
// class, memory waits, reset abort, illegal halt and retire-counter wrap.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [6:0] Op;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite, ALUSrc;
    logic [4:0] ALUOp;
    logic [5:0] EXTOp;
    logic [2:0] NPCOp;
    logic [1:0] WDSel;
    logic [2:0] DMType;
    logic       retire;
    logic [3:0] instret;
    logic       illegal;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_instret = 4'd0;
    int         halt_reqs;

    mc_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct7(Funct7), .Funct3(Funct3),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .EXTOp(EXTOp), .NPCOp(NPCOp), .WDSel(WDSel),
        .DMType(DMType), .retire(retire), .instret(instret),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite, ALUSrc, retire}
    function automatic logic [7:0] strobes();
        return {mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite, ALUSrc, retire};
    endfunction

    task automatic cyc(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    task automatic fetch(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        cyc(1'b1);
        Op = op; Funct3 = f3; Funct7 = f7;
        check("if_strb", strobes(), 8'b1001_1000);
        check("if_npc", NPCOp, 3'b000);
        check("instret", instret, exp_instret);
        cyc(1'b1);
        check("id_strb", strobes(), 8'b0000_0000);
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] alu,
                           input logic [5:0] ext, input logic src);
        fetch(op, f3, f7);
        cyc(1'b1);
        check("ex_strb", strobes(), {6'b0, src, 1'b0});
        check("ex_aluop", ALUOp, alu);
        check("ex_extop", EXTOp, ext);
        cyc(1'b1);
        check("wb_strb", strobes(), 8'b0000_0101);
        check("wb_wdsel", WDSel, 2'b00);
        exp_instret++;
    endtask

    task automatic run_branch(input logic z, input logic [7:0] strb,
                              input logic [2:0] npc);
        fetch(7'h63, 3'b000, 7'h00);
        Zero = z;
        cyc(1'b1);
        check("br_strb", strobes(), strb);
        check("br_npc", NPCOp, npc);
        check("br_aluop", ALUOp, 5'd18);
        check("br_extop", EXTOp, 6'b000100);
        exp_instret++;
    endtask

    task automatic run_jump(input logic [6:0] op, input logic [7:0] strb,
                            input logic [2:0] npc, input logic [5:0] ext);
        fetch(op, 3'b000, 7'h00);
        cyc(1'b1);
        check("j_ex_strb", strobes(), strb);
        check("j_npc", NPCOp, npc);
        check("j_extop", EXTOp, ext);
        cyc(1'b1);
        check("j_wb_strb", strobes(), 8'b0000_0101);
        check("j_wdsel", WDSel, 2'b10);
        exp_instret++;
    endtask

    initial begin
        rstn = 1'b0; mem_ready = 1'b1; Zero = 1'b0;
        Op = 7'h00; Funct3 = 3'b000; Funct7 = 7'h00;
        repeat (2) @(negedge clk);
        #1;
        check("rst_strb", strobes(), 8'b0);
        check("rst_instret", instret, 32'd0);
        check("rst_illegal", illegal, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        rstn = 1'b1;
        #1;
        check("first_req", strobes(), 8'b1000_0000);

        // add x3,x1,x2 then a spread of ALU encodings
        run_alu(7'h33, 3'b000, 7'h00, 5'd3,  6'b000000, 1'b0);
        run_alu(7'h33, 3'b000, 7'h20, 5'd4,  6'b000000, 1'b0);
        run_alu(7'h33, 3'b101, 7'h20, 5'd17, 6'b000000, 1'b0);
        run_alu(7'h13, 3'b100, 7'h00, 5'd12, 6'b010000, 1'b1);
        run_alu(7'h13, 3'b001, 7'h00, 5'd15, 6'b100000, 1'b1);
        run_alu(7'h37, 3'b000, 7'h00, 5'd1,  6'b000010, 1'b1);
        run_alu(7'h17, 3'b000, 7'h00, 5'd2,  6'b000010, 1'b1);

        // lw x5,8(x1) with two wait cycles in S_MEM
        fetch(7'h03, 3'b010, 7'h00);
        cyc(1'b1);
        check("lw_ex_strb", strobes(), 8'b0000_0010);
        check("lw_extop", EXTOp, 6'b010000);
        cyc(1'b0);
        check("lw_mem0", strobes(), 8'b1010_0000);
        check("lw_dmtype", DMType, 3'b000);
        cyc(1'b0);
        check("lw_mem1", strobes(), 8'b1010_0000);
        cyc(1'b1);
        check("lw_mem2", strobes(), 8'b1010_0000);
        cyc(1'b1);
        check("lw_wb_strb", strobes(), 8'b0000_0101);
        check("lw_wdsel", WDSel, 2'b01);
        exp_instret++;

        run_branch(1'b1, 8'b0000_1001, 3'b001);
        run_branch(1'b0, 8'b0000_0001, 3'b000);
        run_jump(7'h6F, 8'b0000_1000, 3'b010, 6'b000001);
        run_jump(7'h67, 8'b0000_1010, 3'b100, 6'b010000);

        // sh with immediate completion
        fetch(7'h23, 3'b001, 7'h00);
        cyc(1'b1);
        check("sh_ex_strb", strobes(), 8'b0000_0010);
        check("sh_extop", EXTOp, 6'b001000);
        cyc(1'b1);
        check("sh_mem", strobes(), 8'b1110_0001);
        check("sh_dmtype", DMType, 3'b001);
        exp_instret++;

        // sw stalled in S_MEM, then reset aborts it
        fetch(7'h23, 3'b010, 7'h00);
        cyc(1'b1);
        cyc(1'b0);
        check("sw_wait", strobes(), 8'b1110_0000);
        check("sw_no_retire_cnt", instret, exp_instret);
        #1 rstn = 1'b0;
        #1;
        check("abort_strb", strobes(), 8'b0);
        check("abort_instret", instret, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("restart_req", strobes(), 8'b1000_0000);
        exp_instret = 4'd0;

        // 16 retires on a 4-bit counter wrap back to zero
        for (int i = 0; i < 16; i++)
            run_branch(1'b0, 8'b0000_0001, 3'b000);

        fetch(7'h7F, 3'b000, 7'h00);
        check("wrap_zero", instret, 32'd0);
        halt_reqs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
            if (mem_req) halt_reqs++;
            check("halt_strb", strobes(), 8'b0);
        end
        check("halt_reqs", halt_reqs, 32'd0);
        check("illegal_set", illegal, 1'b1);
        #1 rstn = 1'b0;
        #1;
        check("illegal_clr", illegal, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        rstn = 1'b1;
        #1;
        check("refetch_req", strobes(), 8'b1000_0000);
        exp_instret = 4'd0;
        run_alu(7'h33, 3'b111, 7'h00, 5'd14, 6'b000000, 1'b0);
        cyc(1'b0);
        check("final_instret", instret, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
